// File: rtl/frame_deframer.sv
// Receive-side frame deframer: hunts for the FAS, confirms alignment, then
// flywheels row/column position and forwards payload columns to the client.
module frame_deframer #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 1041,
    parameter int OH_COLS        = 16,
    parameter int CONFIRM_FRAMES = 1,
    parameter int LOSS_FRAMES    = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [7:0]                  i_line_data,
    input  logic                        i_line_data_valid,
    output logic [7:0]                  o_pyld_data,
    output logic                        o_pyld_data_valid,
    output logic [$clog2(NUM_ROWS)-1:0] o_row_cnt,
    output logic [$clog2(NUM_COLS)-1:0] o_col_cnt,
    output logic                        o_frame_start,
    output logic                        o_in_frame
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int FW = $clog2(CONFIRM_FRAMES + 1);
    localparam int LW = $clog2(LOSS_FRAMES + 1);
    localparam logic [47:0] FAS = 48'hF6F6F6282828;

    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    state_t        state, state_nxt;
    logic [47:0]   sr;
    logic [RW-1:0] row, row_nxt, row_inc, pos_row;
    logic [CW-1:0] col, col_nxt, col_inc, pos_col;
    logic [FW-1:0] conf, conf_nxt;
    logic [LW-1:0] miss, miss_nxt;
    logic          match, fas_pos, col_last, pyld_col;

    // row/col always hold the position of the byte currently on the input
    assign match    = ({sr[39:0], i_line_data} == FAS);
    assign fas_pos  = (row == '0) && (col == CW'(5));
    assign col_last = (col == CW'(NUM_COLS - 1));
    assign col_inc  = col_last ? '0 : col + 1'b1;
    assign row_inc  = !col_last ? row : (row == RW'(NUM_ROWS - 1)) ? '0 : row + 1'b1;
    assign pyld_col = (col >= CW'(OH_COLS)) && (col <= CW'(NUM_COLS - 2));
    assign o_in_frame = (state == LOCK);

    always_comb begin
        state_nxt = state;
        row_nxt   = row_inc;
        col_nxt   = col_inc;
        conf_nxt  = conf;
        miss_nxt  = miss;
        case (state)
            HUNT: begin
                if (match) begin
                    state_nxt = SYNC;
                    row_nxt   = '0;
                    col_nxt   = CW'(6);
                    conf_nxt  = '0;
                end
            end
            SYNC: begin
                if (fas_pos) begin
                    if (match) begin
                        conf_nxt = conf + 1'b1;
                        if (conf_nxt == FW'(CONFIRM_FRAMES)) begin
                            state_nxt = LOCK;
                            miss_nxt  = '0;
                        end
                    end else begin
                        state_nxt = HUNT;
                    end
                end
            end
            LOCK: begin
                if (fas_pos) begin
                    if (match) begin
                        miss_nxt = '0;
                    end else begin
                        miss_nxt = miss + 1'b1;
                        if (miss_nxt == LW'(LOSS_FRAMES)) state_nxt = HUNT;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // a HUNT byte that just matched is by definition row 0 column 5
    always_comb begin
        pos_row = row;
        pos_col = col;
        if (state_nxt == HUNT) begin
            pos_row = '0;
            pos_col = '0;
        end else if (state == HUNT) begin
            pos_row = '0;
            pos_col = CW'(5);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= HUNT;
        end else if (i_line_data_valid) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sr                <= '0;
            row               <= '0;
            col               <= '0;
            conf              <= '0;
            miss              <= '0;
            o_pyld_data       <= '0;
            o_pyld_data_valid <= 1'b0;
            o_row_cnt         <= '0;
            o_col_cnt         <= '0;
            o_frame_start     <= 1'b0;
        end else begin
            o_pyld_data_valid <= 1'b0;
            o_frame_start     <= 1'b0;
            if (i_line_data_valid) begin
                sr                <= {sr[39:0], i_line_data};
                row               <= row_nxt;
                col               <= col_nxt;
                conf              <= conf_nxt;
                miss              <= miss_nxt;
                o_pyld_data       <= i_line_data;
                o_pyld_data_valid <= (state_nxt == LOCK) && pyld_col;
                o_row_cnt         <= pos_row;
                o_col_cnt         <= pos_col;
                o_frame_start     <= (state == LOCK) && (row == '0) && (col == '0);
            end
        end
    end
endmodule

// File: tb/tb_frame_deframer.sv
// Bench for frame_deframer: a stream-index alignment model checked every cycle,
// plus hand-computed checkpoints along a directed sequence of frames.
module tb_frame_deframer;
    localparam int COLS  = 1041;
    localparam int FRAME = 4 * COLS;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_line_data;
    logic        i_line_data_valid;
    logic [7:0]  o_pyld_data;
    logic        o_pyld_data_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_frame_start;
    logic        o_in_frame;

    frame_deframer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_line_data(i_line_data),
        .i_line_data_valid(i_line_data_valid), .o_pyld_data(o_pyld_data),
        .o_pyld_data_valid(o_pyld_data_valid), .o_row_cnt(o_row_cnt),
        .o_col_cnt(o_col_cnt), .o_frame_start(o_frame_start), .o_in_frame(o_in_frame)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int pcount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: alignment is remembered as the stream index of the matching FAS
    // byte; position of any later byte is its frame-relative offset from it.
    int         mst = 0;          // 0 hunt, 1 sync, 2 lock
    int         kidx = 0, anchor = 0, conf = 0, miss = 0;
    logic [7:0] hist[$];
    bit         started = 0;
    logic       e_v, e_fs, e_inf, chk_d;
    logic [7:0] e_data;
    int         e_row, e_col;

    always @(posedge i_clk) begin
        logic r, v, match;
        logic [7:0] d;
        int p, pre;
        r = i_rst; v = i_line_data_valid; d = i_line_data;
        if (!r) begin
            started = 1;
            mst = 0; kidx = 0; anchor = 0; conf = 0; miss = 0;
            hist.delete();
            for (int i = 0; i < 6; i++) hist.push_back(8'h00);
            e_v = 0; e_fs = 0; e_row = 0; e_col = 0; e_data = 0; chk_d = 1;
        end else if (v) begin
            hist.push_back(d);
            void'(hist.pop_front());
            match = (hist[0] == 8'hF6) && (hist[1] == 8'hF6) && (hist[2] == 8'hF6) &&
                    (hist[3] == 8'h28) && (hist[4] == 8'h28) && (hist[5] == 8'h28);
            pre = mst;
            p = (kidx - anchor + 5) % FRAME;
            if (mst == 0) begin
                if (match) begin mst = 1; anchor = kidx; conf = 0; p = 5; end
            end else if (p == 5) begin
                if (mst == 1) begin
                    if (match) begin conf++; if (conf >= 1) begin mst = 2; miss = 0; end end
                    else mst = 0;
                end else begin
                    if (match) miss = 0;
                    else begin miss++; if (miss >= 3) mst = 0; end
                end
            end
            e_v    = (mst == 2) && (p % COLS >= 16) && (p % COLS <= COLS - 2);
            e_fs   = (pre == 2) && (p == 0);
            e_row  = (mst == 0) ? 0 : p / COLS;
            e_col  = (mst == 0) ? 0 : p % COLS;
            e_data = d;
            chk_d  = e_v;
            kidx++;
        end else begin
            e_v = 0; e_fs = 0; chk_d = 0;
        end
        e_inf = (mst == 2);
        #1;
        if (started) begin
            chk("m_valid", o_pyld_data_valid, e_v);
            chk("m_fstart", o_frame_start, e_fs);
            chk("m_inframe", o_in_frame, e_inf);
            chk("m_row", o_row_cnt, e_row);
            chk("m_col", o_col_cnt, e_col);
            if (chk_d) chk("m_data", o_pyld_data, e_data);
        end
        if (o_pyld_data_valid === 1'b1) pcount++;
    end

    task automatic send(input logic [7:0] d, input logic v, input logic rst);
        @(negedge i_clk);
        i_line_data = d; i_line_data_valid = v; i_rst = rst;
    endtask

    task automatic settle();
        @(posedge i_clk);
        #2;
    endtask

    task automatic hook(input int tag, input int r, input int c);
        if (tag == 1 && r == 0 && c == 5) begin
            settle(); chk("t1_sync_col", o_col_cnt, 5); chk("t1_sync_inf", o_in_frame, 0);
        end
        if (tag == 2 && r == 0 && c == 5) begin settle(); chk("t2_lock", o_in_frame, 1); end
        if (tag == 2 && r == 0 && c == 15) begin settle(); chk("t2_col15", o_pyld_data_valid, 0); end
        if (tag == 2 && r == 0 && c == 16) begin
            settle(); chk("t2_first_v", o_pyld_data_valid, 1); chk("t2_first_d", o_pyld_data, 8'h10);
        end
        if (tag == 3 && r == 0 && c == 0) begin settle(); chk("t3_fstart", o_frame_start, 1); end
        if ((tag == 7 || tag == 8) && r == 0 && c == 5) begin
            settle(); chk("loss_hold", o_in_frame, 1);
        end
        if (tag == 9 && r == 0 && c == 5) begin settle(); chk("loss_drop", o_in_frame, 0); end
        if (tag == 14 && r == 2 && c == 500) begin
            settle();
            chk("rst_inf", o_in_frame, 0); chk("rst_v", o_pyld_data_valid, 0);
            chk("rst_row", o_row_cnt, 0); chk("rst_col", o_col_cnt, 0);
            chk("rst_data", o_pyld_data, 0); chk("rst_fs", o_frame_start, 0);
        end
        if (tag == 15 && r == 0 && c == 5) begin
            settle(); chk("reacq_col", o_col_cnt, 5); chk("reacq_inf", o_in_frame, 0);
        end
    endtask

    task automatic frame(input int tag, input bit bad, input bit gap);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic [7:0] b;
                b = c[7:0];
                if (r == 0 && c < 6) b = (c < 3) ? 8'hF6 : 8'h28;
                if (r == 0 && c == 3 && bad) b = 8'h29;
                send(b, 1'b1, !(tag == 14 && r == 2 && c == 500));
                hook(tag, r, c);
                if (gap) send(8'($urandom_range(0, 255)), 1'b0, 1'b1);
            end
        end
    endtask

    task automatic rand_bytes(input int n);
        for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    endtask

    initial begin
        int base;
        i_rst = 1'b0; i_line_data = 8'h00; i_line_data_valid = 1'b0;
        repeat (3) send(8'h00, 1'b0, 1'b0);
        settle();
        chk("reset_inf", o_in_frame, 0);
        chk("reset_v", o_pyld_data_valid, 0);

        // aligned stream
        base = pcount; frame(1, 0, 0); chk("t1_cnt", pcount - base, 0);
        base = pcount; frame(2, 0, 0); chk("t2_cnt", pcount - base, 4096);
        base = pcount; frame(3, 0, 0); chk("t3_cnt", pcount - base, 4096);

        // loss of frame: two misses, recovery, three misses
        frame(4, 1, 0); frame(5, 1, 0); frame(6, 0, 0); frame(7, 1, 0);
        base = pcount; frame(8, 1, 0); chk("t8_cnt", pcount - base, 4096);
        base = pcount; frame(9, 1, 0); chk("t9_cnt", pcount - base, 0);

        // false FAS in random data, no confirmation a frame later
        base = pcount;
        rand_bytes(20);
        send(8'hF6, 1, 1); send(8'hF6, 1, 1); send(8'hF6, 1, 1);
        send(8'h28, 1, 1); send(8'h28, 1, 1); send(8'h28, 1, 1);
        settle(); chk("fl_sync_col", o_col_cnt, 5); chk("fl_sync_row", o_row_cnt, 0);
        rand_bytes(FRAME - 1);
        settle(); chk("fl_col4", o_col_cnt, 4);
        send(8'h00, 1, 1);
        settle(); chk("fl_hunt_col", o_col_cnt, 0); chk("fl_inf", o_in_frame, 0);
        send(8'h00, 1, 1);
        settle(); chk("fl_hunt_next", o_col_cnt, 0);
        chk("fl_cnt", pcount - base, 0);

        // unaligned start
        rand_bytes(100);
        base = pcount; frame(10, 0, 0); chk("t10_cnt", pcount - base, 0);
        base = pcount; frame(11, 0, 0); chk("t11_cnt", pcount - base, 4096);
        frame(12, 0, 0);

        // gapped valid
        base = pcount; frame(13, 0, 1); chk("gap_cnt", pcount - base, 4096);

        // reset mid-frame then reacquire
        frame(14, 0, 0);
        base = pcount; frame(15, 0, 0); chk("t15_cnt", pcount - base, 0);
        base = pcount; frame(16, 0, 0); chk("t16_cnt", pcount - base, 4096);

        repeat (4) send(8'h00, 1'b0, 1'b1);
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_deframer.md
Name: frame_deframer

Overview:
- Receive-side counterpart of the sender frame mapper.
- Takes the serialised line byte stream and hunts for the frame alignment signal (FAS = F6 F6 F6 28 28 28 at row 0, columns 0-5). Once locked, it tracks row/column position and extracts payload bytes back to the client interface.
- Sits between the line receive path and the client sink. It reports alignment status for monitoring.

Parameters:
- NUM_ROWS, 4, rows per frame
- NUM_COLS, 1041, columns per row (0..1040)
- OH_COLS, 16, overhead columns per row (0..15)
- CONFIRM_FRAMES, 1, consecutive FAS matches needed in SYNC before LOCK
- LOSS_FRAMES, 3, consecutive FAS misses in LOCK before returning to HUNT

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_rst  input  1  synchronous reset, active-low (asserted when 0)
- i_line_data  input  8  received line byte
- i_line_data_valid  input  1  line byte qualifier; the block ignores all inputs when low
- o_pyld_data  output  8  extracted payload byte
- o_pyld_data_valid  output  1  payload qualifier
- o_row_cnt  output  2  row of the current output byte
- o_col_cnt  output  11  column of the current output byte
- o_frame_start  output  1  one-cycle pulse when row 0 col 0 is output while in LOCK
- o_in_frame  output  1  high while state is LOCK

Behaviour:
- Reset (i_rst=0 at clock edge):
  - state=HUNT; all outputs 0; counters 0.
  - 6-byte FAS shift register cleared to 00.
  - Reset takes effect mid-frame with no flush.
- General rules:
  - Every state update happens only on cycles with i_line_data_valid=1.
  - Invalid cycles hold all state and drive o_pyld_data_valid=0 and o_frame_start=0 on the next cycle.
- Shift register sr[47:0]:
  - On each valid byte, sr <= {sr[39:0], i_line_data}.
  - Define match = ({sr[39:0], i_line_data} == F6F6F6282828).
- Position counters (row, col):
  - col increments on each valid byte.
  - At col=NUM_COLS-1, col wraps to 0 and row increments.
  - Row wraps from NUM_ROWS-1 to 0.
- States:
  - HUNT: counters free-run and are ignored. On a valid byte with match=1, set row=0, col=6 so the next byte is column 6, clear the confirm counter, and go to SYNC.
  - SYNC: on the valid byte at row 0 col 5:
    - if match=1: increment the confirm counter; when it reaches CONFIRM_FRAMES, go to LOCK and clear the miss counter.
    - if match=0: go to HUNT. The shift register is kept, and hunting resumes on the next valid byte.
  - LOCK: on the valid byte at row 0 col 5:
    - if match=1: clear the miss counter.
    - if match=0: increment the miss counter; when it reaches LOSS_FRAMES, go to HUNT.
    - Position counters keep running on a miss (flywheel); no realignment occurs inside LOCK.
- Payload extraction:
  - Latency is exactly 1 cycle: an input byte accepted at edge N appears on o_pyld_data after edge N.
  - o_pyld_data_valid=1 only when all of the following hold:
    - state is LOCK for that byte, evaluated after any transition on that same byte;
    - OH_COLS <= col <= NUM_COLS-2, i.e. columns 16..1039;
    - the input was valid.
  - Column 1040 (stuff) and columns 0..15 are never forwarded.
  - o_pyld_data carries the registered input byte every valid cycle; it is don't-care when valid=0.
- Position outputs:
  - o_row_cnt/o_col_cnt are registered alongside the data and describe the same byte.
  - They read 0 when not in SYNC/LOCK.
- o_frame_start:
  - Pulses for the byte at row 0 col 0 only when state is LOCK before that byte.
- Boundary cases:
  - LOCK entry happens at col 5, so payload from col 16 of that same frame is forwarded.
  - The LOCK→HUNT transition on the LOSS_FRAMES-th miss suppresses payload from the next byte onward.
  - FAS-like patterns inside payload are ignored in SYNC/LOCK.

Test Plan:
- Reset then aligned stream:
  - Stimulus: 3 back-to-back frames, FAS at start, payload bytes = col[7:0], continuous valid.
  - Required response:
    - SYNC after byte 5; LOCK at frame 2 col 5.
    - Exactly 4096 payload valids in frame 2 (frame 1 forwards none), first byte 0x10 one cycle after input col 16.
    - o_frame_start at frame 3 col 0.
- Unaligned start:
  - Stimulus: 100 random bytes, then the aligned stream.
  - Required response: no payload valid before LOCK; o_row_cnt/o_col_cnt correct after SYNC.
- Gapped valid:
  - Stimulus: i_line_data_valid toggling 1/0 on an aligned stream.
  - Required response: identical payload sequence to the continuous case; o_pyld_data_valid never high on the cycle after an invalid input.
- Loss of frame:
  - Stimulus: in LOCK, corrupt FAS byte 3 (0x28→0x29) in 2 frames, then 1 good frame, then 3 bad frames.
  - Required response: stays LOCK through the first two misses (counter resets on the good frame); HUNT at the 3rd consecutive miss col 5; o_in_frame falls next cycle; payload stops.
- SYNC false lock:
  - Stimulus: FAS pattern embedded in random data, with no FAS one frame later.
  - Required response: SYNC then HUNT at the expected col 5; no payload output.
- Reset mid-frame:
  - Stimulus: i_rst=0 for 1 cycle during LOCK at row 2 col 500.
  - Required response: next cycle all outputs 0, state HUNT; reacquires on the following FAS.
